coremem_pipe: RTL
=================

Name: coremem_pipe

Overview:
Parametrised bridge between the core LSU data port (req/gnt/rvalid) and a single-port synchronous SRAM.
- Grants up to MAX_OUT outstanding accesses and handles SRAM read latency set by LATENCY.
- Supports byte-enabled writes and returns exactly one in-order rvalid per granted request.
- Sits between core data port and local data SRAM. Sustains one access per cycle when MAX_OUT >= LATENCY.

Parameters:
ADDR_W, 16, SRAM word-address width (depth = 2**ADDR_W words)
DATA_W, 32, data width; multiple of 8
LATENCY, 1, SRAM cycles from CE to valid rdata; legal 1..4
MAX_OUT, 2, max granted-but-unanswered requests; legal 1..4

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
data_req_i  in  1  core request
data_gnt_o  out  1  request accepted this cycle
data_rvalid_o  out  1  response for oldest outstanding request
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  DATA_W/8  byte enables
data_addr_i  in  32  byte address
data_wdata_i  in  DATA_W  write data
data_rdata_o  out  DATA_W  read data, valid with rvalid
data_err_o  out  1  error response (see Optional Feature)
sram_ce_o  out  1  SRAM chip enable
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  ADDR_W  SRAM word address = data_addr_i[ADDR_W+1:2]
sram_be_o  out  DATA_W/8  SRAM byte write mask
sram_wdata_o  out  DATA_W  SRAM write data
sram_rdata_i  in  DATA_W  SRAM read data

Behaviour:
- Reset: outstanding counter = 0; response pipeline cleared; data_gnt_o = 0; data_rvalid_o = 0; data_err_o = 0; data_rdata_o = 0; sram_ce_o = 0; sram_we_o = 0.
- Grant (combinational): data_gnt_o = data_req_i && (cnt < MAX_OUT || resp_now), where resp_now is the token leaving the pipeline this cycle.
- Core may drop data_req_i without a grant. Request fields are sampled only in the grant cycle.
- SRAM strobe is issued in the grant cycle:
  - sram_ce_o = data_gnt_o.
  - sram_we_o = data_gnt_o & data_we_i.
  - sram_be_o = data_be_i when writing, else 0.
  - sram_addr_o and sram_wdata_o pass through combinationally.
- Response pipeline: LATENCY-deep shift register of {valid, we, err} tokens. A token is pushed on grant and shifts every cycle.
- Response timing: data_rvalid_o asserts exactly LATENCY cycles after the grant, for reads and writes alike, with no stall.
- Response data:
  - Read: data_rdata_o = sram_rdata_i in the rvalid cycle.
  - Write: data_rdata_o = 0.
  - Non-rvalid cycles: data_rdata_o = 0.
- Counter, width clog2(MAX_OUT+1):
  - +1 on grant; -1 on rvalid; unchanged on simultaneous grant and rvalid.
  - Never exceeds MAX_OUT and never underflows. Violation is a design error and must be flagged by an assertion.
- Ordering: responses strictly in grant order. Read-after-write to the same address, issued back to back, returns the written data.
- Throughput: MAX_OUT >= LATENCY gives one grant per cycle. Otherwise grants repeat in a pattern of MAX_OUT grants per LATENCY cycles.
- Address bits [1:0] are ignored (word-aligned access).
- Reset mid-operation: all in-flight tokens discarded. No rvalid is produced for requests granted before reset. The first request after reset release is granted in its first cycle.

Optional Feature:
Macro COREMEM_PIPE_ERR_EN.
- Defined:
  - A request with data_addr_i[31:ADDR_W+2] != 0 is granted normally.
  - sram_ce_o and sram_we_o are suppressed for that request.
  - Its token carries err = 1. The response arrives LATENCY cycles later with data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
- Undefined:
  - Upper address bits are ignored and the address aliases into the SRAM.
  - data_err_o is tied to 0. The port remains present so the interface is stable.

Test Plan:
- LATENCY=1, MAX_OUT=2: reads at 0x0, 0x4, 0x8 on consecutive cycles, SRAM preloaded 0x11, 0x22, 0x33 -> gnt on every cycle; rvalid one cycle after each grant; rdata 0x11, 0x22, 0x33 in order.
- Write 0xAABBCCDD with be=4'b0011 to 0x10 (previously 0), then read 0x10 -> write rvalid with rdata 0; read returns 0x0000CCDD.
- LATENCY=3, MAX_OUT=2, req held high -> grants at cycles 0, 1, 3, 4, 6, 7; rvalid at cycles 3, 4, 6, 7, 9, 10; counter stays at 2 through simultaneous grant/rvalid cycles.
- LATENCY=2, two reads granted, rst_ni pulsed low one cycle later -> no rvalid ever for those reads; next req granted in first cycle after release.
- Write then read to the same address on back-to-back cycles, LATENCY=2 -> read returns the new data; rvalids in order.
- COREMEM_PIPE_ERR_EN, ADDR_W=16: read 0x0004_0000 -> sram_ce_o stays 0; LATENCY cycles later rvalid=1, err=1, rdata=0. Same stimulus without the macro -> ce=1 at SRAM word address 0, err=0.

Source files
------------

// File: rtl/coremem_pipe.sv
// Core LSU data port (req/gnt/rvalid) to single-port synchronous SRAM bridge.
// Define COREMEM_PIPE_ERR_EN to return error responses for out-of-range addresses.
module coremem_pipe #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [31:0]         data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    output logic                sram_ce_o,
    output logic                sram_we_o,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W/8-1:0] sram_be_o,
    output logic [DATA_W-1:0]   sram_wdata_o,
    input  logic [DATA_W-1:0]   sram_rdata_i
);

    localparam int unsigned CntW = $clog2(MAX_OUT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUT);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [LATENCY-1:0] we_q, we_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               addr_err;
    logic               resp_now;
    logic               gnt;
    logic               unused_addr;

`ifdef COREMEM_PIPE_ERR_EN
    assign addr_err    = |data_addr_i[31:ADDR_W+2];
    assign unused_addr = ^data_addr_i[1:0];
`else
    // Upper address bits alias into the SRAM.
    assign addr_err    = 1'b0;
    assign unused_addr = ^{data_addr_i[31:ADDR_W+2], data_addr_i[1:0]};
`endif

    assign resp_now = valid_q[LATENCY-1];
    // Gated by reset so no grant (and hence no SRAM strobe) escapes while in reset.
    assign gnt      = rst_ni & data_req_i & ((cnt_q < MaxCnt) | resp_now);

    always_comb begin
        valid_d    = '0;
        we_d       = '0;
        err_d      = '0;
        valid_d[0] = gnt;
        we_d[0]    = gnt & data_we_i;
        err_d[0]   = gnt & addr_err;
        for (int i = 1; i < int'(LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            we_d[i]    = we_q[i-1];
            err_d[i]   = err_q[i-1];
        end

        cnt_d = cnt_q;
        if (gnt && !resp_now) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!gnt && resp_now) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            we_q    <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = resp_now;
    assign data_err_o    = resp_now & err_q[LATENCY-1];
    assign data_rdata_o  = (resp_now && !we_q[LATENCY-1] && !err_q[LATENCY-1]) ?
                           sram_rdata_i : '0;

    assign sram_ce_o    = gnt & ~addr_err;
    assign sram_we_o    = gnt & ~addr_err & data_we_i;
    assign sram_be_o    = sram_we_o ? data_be_i : '0;
    assign sram_addr_o  = data_addr_i[ADDR_W+1:2];
    assign sram_wdata_o = data_wdata_i;

`ifndef SYNTHESIS
    cnt_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MaxCnt)
        else $error("outstanding counter exceeds MAX_OUT");
    cnt_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_now && cnt_q == '0))
        else $error("response with no outstanding request");
`endif

endmodule
